mem_bus_arbiter: RTL and testbench

Parametrised N-port memory bus arbiter that lets several word-addressed masters share one main-memory port. Example masters are the CPU data port, the CPU instruction port, the GPU and a future DMA. It replaces fixed point-to-point memory wiring at system top. Features:
- Round-robin or fixed-priority arbitration.
- Byte-lane writes.
- Per-transaction timeout that reports an error instead of hanging the system.

---
 rtl/mem_bus_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// N-port memory bus arbiter: round-robin or fixed-priority grant of one shared
// word-addressed memory port, with byte-lane writes and a per-transfer timeout.
module mem_bus_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
  output logic [DATA_W-1:0]               req_rdata,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]            req_err,
  output logic                            mem_read,
  output logic [DATA_W/8-1:0]             mem_write,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata,
  input  logic                            mem_ready,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
  output logic                            busy
);

  localparam int BE_W = DATA_W / 8;
  localparam int IDW  = $clog2(NUM_PORTS);
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TLIM    = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [DATA_W-1:0]  req_rdata_q, req_rdata_d;
  logic [NUM_PORTS-1:0] req_ready_q, req_ready_d;
  logic [NUM_PORTS-1:0] req_err_q, req_err_d;
  logic               mem_read_q, mem_read_d;
  logic [BE_W-1:0]    mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               busy_q, busy_d;

  logic [NUM_PORTS-1:0] req_any;
  logic               found_hi, found_lo, found;
  logic [IDW-1:0]     win_hi, win_lo, win;
  logic [BE_W-1:0]    win_be;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      req_any[i] = req_read[i] | (|req_write[i*BE_W +: BE_W]);
    end
  end

  // Round-robin as two ascending scans: ports at/above rr_ptr first, then the
  // wrapped ones below it. Fixed priority routes every port into the low scan.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (req_any[i]) begin
        if ((PRIO_MODE == 0) && (IDW'(i) >= rr_ptr_q)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            win_hi   = IDW'(i);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          win_lo   = IDW'(i);
        end
      end
    end
    found = found_hi | found_lo;
    win   = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    win_be    = '0;
    win_addr  = '0;
    win_wdata = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (IDW'(i) == win) begin
        win_be    = req_write[i*BE_W +: BE_W];
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    tcnt_d      = tcnt_q;
    req_rdata_d = '0;
    req_ready_d = '0;
    req_err_d   = '0;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = BUSY;
          grant_id_d  = win;
          mem_addr_d  = win_addr;
          mem_wdata_d = win_wdata;
          tcnt_d      = '0;
          busy_d      = 1'b1;
          // A write with req_read also set is still a write.
          if (win_be != '0) begin
            mem_write_d = win_be;
            mem_read_d  = 1'b0;
          end else begin
            mem_write_d = '0;
            mem_read_d  = 1'b1;
          end
        end
      end
      BUSY: begin
        tcnt_d = tcnt_q + 1'b1;
        if (mem_ready) begin
          state_d                 = DONE;
          mem_read_d              = 1'b0;
          mem_write_d             = '0;
          req_ready_d[grant_id_q] = 1'b1;
          if (mem_read_q) begin
            req_rdata_d = mem_rdata;
          end
        end else if ((TIMEOUT != 0) && (tcnt_q == TLIM)) begin
          state_d                 = DONE;
          mem_read_d              = 1'b0;
          mem_write_d             = '0;
          req_ready_d[grant_id_q] = 1'b1;
          req_err_d[grant_id_q]   = 1'b1;
        end
      end
      DONE: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = '0;
        if (PRIO_MODE == 0) begin
          rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      tcnt_q      <= '0;
      req_rdata_q <= '0;
      req_ready_q <= '0;
      req_err_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      tcnt_q      <= tcnt_d;
      req_rdata_q <= req_rdata_d;
      req_ready_q <= req_ready_d;
      req_err_q   <= req_err_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign req_rdata = req_rdata_q;
  assign req_ready = req_ready_q;
  assign req_err   = req_err_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready_q));
  a_err_with_ready: assert property (@(posedge clk) disable iff (!rst_n) (req_err_q & ~req_ready_q) == '0);
  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mem_read_q && (mem_write_q != '0)));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin/TIMEOUT=4 instance and a
// fixed-priority/TIMEOUT=0 instance share stimulus; checks select one of them.
module tb_mem_bus_arbiter;

  localparam int NP    = 3;
  localparam int AW    = 30;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int TMO_A = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NP-1:0]    req_read;
  logic [NP*BW-1:0] req_write;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [DW-1:0]    mem_rdata;
  logic             mem_ready;

  logic [DW-1:0] a_rdata, b_rdata, o_rdata;
  logic [NP-1:0] a_ready, b_ready, o_ready, a_err, b_err, o_err;
  logic          a_mrd, b_mrd, o_mrd, a_busy, b_busy, o_busy;
  logic [BW-1:0] a_mwr, b_mwr, o_mwr;
  logic [AW-1:0] a_maddr, b_maddr, o_maddr;
  logic [DW-1:0] a_mwd, b_mwd, o_mwd;
  logic [1:0]    a_gid, b_gid, o_gid;

  mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0), .TIMEOUT(TMO_A)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(a_rdata),
    .req_ready(a_ready), .req_err(a_err), .mem_read(a_mrd), .mem_write(a_mwr),
    .mem_addr(a_maddr), .mem_wdata(a_mwd), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .grant_id(a_gid), .busy(a_busy));

  mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1), .TIMEOUT(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdata(b_rdata),
    .req_ready(b_ready), .req_err(b_err), .mem_read(b_mrd), .mem_write(b_mwr),
    .mem_addr(b_maddr), .mem_wdata(b_mwd), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .grant_id(b_gid), .busy(b_busy));

  bit sel;
  always_comb begin
    if (sel) begin
      o_rdata = b_rdata; o_ready = b_ready; o_err = b_err; o_mrd = b_mrd; o_mwr = b_mwr;
      o_maddr = b_maddr; o_mwd = b_mwd; o_gid = b_gid; o_busy = b_busy;
    end else begin
      o_rdata = a_rdata; o_ready = a_ready; o_err = a_err; o_mrd = a_mrd; o_mwr = a_mwr;
      o_maddr = a_maddr; o_mwd = a_mwd; o_gid = a_gid; o_busy = a_busy;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int rr_m    = 0;

  bit            p_rd[NP];
  logic [BW-1:0] p_be[NP];
  logic [AW-1:0] p_addr[NP];
  logic [DW-1:0] p_wd[NP];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < NP; i++) begin
      req_read[i]           = p_rd[i];
      req_write[i*BW +: BW] = p_be[i];
      req_addr[i*AW +: AW]  = p_addr[i];
      req_wdata[i*DW +: DW] = p_wd[i];
    end
  endtask

  task automatic clear_ports();
    for (int i = 0; i < NP; i++) begin
      p_rd[i] = 1'b0; p_be[i] = '0; p_addr[i] = '0; p_wd[i] = '0;
    end
    apply();
  endtask

  task automatic set_port(input int i, input bit rd, input logic [BW-1:0] be,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    p_rd[i] = rd; p_be[i] = be; p_addr[i] = addr; p_wd[i] = wd;
  endtask

  task automatic rand_port(input int i);
    int op;
    op = $urandom_range(0, 3);
    p_rd[i]   = (op != 1);
    p_be[i]   = (op == 1 || op == 2) ? 4'($urandom_range(1, 15)) : 4'h0;
    p_addr[i] = 30'($urandom);
    p_wd[i]   = $urandom;
  endtask

  function automatic logic [NP-1:0] cur_mask();
    logic [NP-1:0] m;
    for (int i = 0; i < NP; i++) m[i] = p_rd[i] || (p_be[i] != '0);
    return m;
  endfunction

  // Next grantee: first requester at or after the pointer (round-robin), or port 0 upward.
  function automatic int pick(input logic [NP-1:0] m, input int rr, input bit prio);
    int start;
    start = prio ? 0 : rr;
    for (int k = 0; k < NP; k++) begin
      if (m[(start + k) % NP]) return (start + k) % NP;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    clear_ports();
    tick();
    tick();
    rst_n = 1'b1;
    rr_m  = 0;
  endtask

  // One transfer starting in an IDLE cycle with requests already applied.
  // The memory answers in BUSY cycle d (cycle 1 = first mem strobe cycle).
  task automatic serve(input int d, input logic [DW-1:0] rv, input bit keep, output int w);
    int e, tmo;
    bit wr, exp_err;
    logic [BW-1:0] be;
    logic [DW-1:0] exp_rd;
    w = pick(cur_mask(), rr_m, sel);
    if (w < 0) begin
      n_fail++;
      $display("FAIL serve_setup: no requester, required at least one");
      return;
    end
    be      = p_be[w];
    wr      = (be != '0);
    tmo     = sel ? 0 : TMO_A;
    exp_err = (tmo != 0) && (d > tmo);
    e       = exp_err ? tmo + 1 : d + 1;
    tick();
    for (int c = 1; c < e; c++) begin
      n_tests++;
      if (o_busy !== 1'b1 || o_gid !== 2'(w) || o_ready !== '0) begin
        n_fail++;
        $display("FAIL busy_ctl: cycle %0d busy=%b gid=%0d ready=%b, required busy=1 gid=%0d ready=000",
                 c, o_busy, o_gid, o_ready, w);
      end
      n_tests++;
      if (o_mrd !== !wr || o_mwr !== (wr ? be : 4'h0)) begin
        n_fail++;
        $display("FAIL strobe: cycle %0d mem_read=%b mem_write=%b, required %b %b",
                 c, o_mrd, o_mwr, !wr, (wr ? be : 4'h0));
      end
      n_tests++;
      if (o_maddr !== p_addr[w] || o_mwd !== p_wd[w]) begin
        n_fail++;
        $display("FAIL mem_addr_data: addr=%h wdata=%h, required %h %h", o_maddr, o_mwd, p_addr[w], p_wd[w]);
      end
      if (c == d) begin
        mem_ready = 1'b1; mem_rdata = rv;
      end else begin
        mem_ready = 1'b0; mem_rdata = $urandom;
      end
      tick();
    end
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    exp_rd = (wr || exp_err) ? '0 : rv;
    n_tests++;
    if (o_ready !== 3'(1 << w)) begin
      n_fail++;
      $display("FAIL ready: cycle %0d req_ready=%b, required %b", e, o_ready, 3'(1 << w));
    end
    n_tests++;
    if (o_err !== (exp_err ? 3'(1 << w) : 3'b000)) begin
      n_fail++;
      $display("FAIL err: req_err=%b, required %b", o_err, (exp_err ? 3'(1 << w) : 3'b000));
    end
    n_tests++;
    if (o_rdata !== exp_rd) begin
      n_fail++;
      $display("FAIL rdata: req_rdata=%h, required %h", o_rdata, exp_rd);
    end
    n_tests++;
    if (o_mrd !== 1'b0 || o_mwr !== '0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_ctl: mem_read=%b mem_write=%b busy=%b, required 0 0000 1", o_mrd, o_mwr, o_busy);
    end
    mem_ready = 1'($urandom_range(0, 1));
    if (!keep) begin
      p_rd[w] = 1'b0; p_be[w] = '0;
      apply();
    end
    if (!sel) rr_m = (w + 1) % NP;
    tick();
    mem_ready = 1'b0;
    n_tests++;
    if (o_busy !== 1'b0 || o_ready !== '0 || o_err !== '0 || o_mrd !== 1'b0 || o_mwr !== '0) begin
      n_fail++;
      $display("FAIL idle_ctl: busy=%b ready=%b err=%b mem_read=%b mem_write=%b, required all 0",
               o_busy, o_ready, o_err, o_mrd, o_mwr);
    end
    n_tests++;
    if (o_gid !== 2'(w) || o_maddr !== p_addr[w]) begin
      n_fail++;
      $display("FAIL idle_hold: gid=%0d mem_addr=%h, required %0d %h", o_gid, o_maddr, w, p_addr[w]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    clear_ports();
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_tests++;
      if ({o_ready, o_err, o_mrd, o_mwr, o_gid, o_busy} !== '0) begin
        n_fail++;
        $display("FAIL reset_ctl: dut%0d ready=%b err=%b rd=%b wr=%b gid=%0d busy=%b, required all 0",
                 s, o_ready, o_err, o_mrd, o_mwr, o_gid, o_busy);
      end
      n_tests++;
      if ({o_rdata, o_maddr, o_mwd} !== '0) begin
        n_fail++;
        $display("FAIL reset_data: dut%0d rdata=%h addr=%h wdata=%h, required 0", s, o_rdata, o_maddr, o_mwd);
      end
    end
    sel = 1'b0;
    rst_n = 1'b1;
    rr_m = 0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_tests++;
    if (o_busy !== 1'b0 || o_ready !== '0) begin
      n_fail++;
      $display("FAIL idle_mem_ready: busy=%b ready=%b, required 0 000", o_busy, o_ready);
    end
  endtask

  task automatic test_single_read();
    int w;
    clear_ports();
    set_port(1, 1'b1, 4'h0, 30'h0000100, 32'h0);
    apply();
    serve(2, 32'hDEADBEEF, 1'b0, w);
  endtask

  task automatic test_byte_write();
    int w;
    set_port(0, 1'b0, 4'b0101, 30'($urandom), 32'h11223344);
    apply();
    serve(1, 32'hCAFEF00D, 1'b0, w);
  endtask

  task automatic test_timeout();
    int w;
    set_port(0, 1'b1, 4'h0, 30'($urandom), $urandom);
    apply();
    serve(100, $urandom, 1'b0, w);
    set_port(1, 1'b0, 4'b1111, 30'($urandom), $urandom);
    apply();
    serve(TMO_A, $urandom, 1'b0, w);
    set_port(2, 1'b1, 4'b1000, 30'($urandom), $urandom);
    apply();
    serve(3, $urandom, 1'b0, w);
  endtask

  task automatic test_round_robin();
    int w;
    do_reset();
    for (int i = 0; i < NP; i++) set_port(i, 1'b1, 4'h0, 30'($urandom), $urandom);
    apply();
    for (int k = 0; k < 6; k++) serve($urandom_range(1, 3), $urandom, 1'b1, w);
    clear_ports();
    tick();
  endtask

  task automatic test_random(input int episodes);
    int w, n;
    logic [NP-1:0] m;
    for (int ep = 0; ep < episodes; ep++) begin
      m = 3'($urandom_range(1, 7));
      for (int i = 0; i < NP; i++) begin
        if (m[i]) rand_port(i);
      end
      apply();
      n = $countones(m);
      for (int t = 0; t < n; t++) serve($urandom_range(1, 6), $urandom, 1'b0, w);
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic test_reset_mid_op();
    int w;
    clear_ports();
    set_port(0, 1'b1, 4'h0, 30'($urandom), $urandom);
    apply();
    tick();
    tick();
    n_tests++;
    if (o_mrd !== 1'b1 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_busy: mem_read=%b busy=%b, required 1 1", o_mrd, o_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_ready, o_err, o_mrd, o_mwr, o_gid, o_busy, o_rdata, o_maddr, o_mwd} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: ready=%b rd=%b busy=%b addr=%h, required all 0", o_ready, o_mrd, o_busy, o_maddr);
    end
    clear_ports();
    set_port(2, 1'b1, 4'h0, 30'($urandom), $urandom);
    apply();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_tests++;
    if (o_ready !== '0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_ready: ready=%b busy=%b, required 000 0", o_ready, o_busy);
    end
    rst_n = 1'b1;
    rr_m = 0;
    serve(2, $urandom, 1'b0, w);
  endtask

  task automatic test_fixed_priority();
    int w;
    for (int i = 0; i < NP; i++) set_port(i, 1'b1, 4'h0, 30'($urandom), $urandom);
    apply();
    for (int k = 0; k < 6; k++) serve($urandom_range(1, 3), $urandom, 1'b1, w);
    p_rd[0] = 1'b0;
    apply();
    serve(2, $urandom, 1'b1, w);
    clear_ports();
    tick();
  endtask

  task automatic test_no_timeout();
    int w;
    set_port(2, 1'b1, 4'h0, 30'($urandom), $urandom);
    apply();
    serve(40, $urandom, 1'b0, w);
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_single_read();
    test_byte_write();
    test_timeout();
    test_round_robin();
    test_random(25);
    test_reset_mid_op();
    do_reset();
    sel = 1'b1;
    test_fixed_priority();
    test_no_timeout();
    test_random(10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
